// File: rtl/parking_gate_arbiter.sv
// Round-robin arbiter sharing one parking datapath between N_GATES gates, with occupancy
// tracking, local rejects and per-gate barrier timers. Define EXIT_PRIORITY_EN to serve exits first.
module parking_gate_arbiter #(
  parameter int unsigned N_GATES     = 4,
  parameter int unsigned SLOTS       = 8,
  parameter int unsigned OPEN_CYCLES = 16,
  parameter int unsigned DP_TIMEOUT  = 32
) (
  input  logic                   clock,
  input  logic                   g1_reset,
  input  logic [N_GATES-1:0]     gate_req,
  input  logic [N_GATES-1:0]     gate_is_exit,
  input  logic [3*N_GATES-1:0]   gate_slot,
  input  logic [8*N_GATES-1:0]   gate_code,
  output logic [N_GATES-1:0]     gate_grant,
  output logic                   gate_ok,
  output logic [N_GATES-1:0]     gate_open,
  output logic                   dp_valid,
  output logic                   dp_exit,
  output logic [2:0]             dp_slot,
  output logic [7:0]             dp_code,
  input  logic                   dp_done,
  input  logic                   dp_ok,
  output logic [3:0]             occupancy,
  output logic                   full
);

  localparam int unsigned GW = (N_GATES > 1) ? $clog2(N_GATES) : 1;
  localparam int unsigned TW = $clog2(OPEN_CYCLES + 1);
  localparam int unsigned CW = (DP_TIMEOUT > 1) ? $clog2(DP_TIMEOUT) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [GW-1:0]      rr_q, rr_d;
  logic [GW-1:0]      win_q, win_d;
  logic [CW-1:0]      tmo_q, tmo_d;
  logic [TW-1:0]      timer_q [N_GATES];
  logic [TW-1:0]      timer_d [N_GATES];
  logic [3:0]         occ_d;
  logic               full_d;
  logic               dp_valid_d, dp_exit_d;
  logic [2:0]         dp_slot_d;
  logic [7:0]         dp_code_d;
  logic [N_GATES-1:0] grant_d, open_d;
  logic               ok_d;
  logic [N_GATES-1:0] cand;
  logic [GW-1:0]      pick;
  logic               pick_rej;

  // First set bit of mask at or after start, wrapping around the gate count.
  function automatic logic [GW-1:0] rr_pick(input logic [N_GATES-1:0] mask,
                                            input logic [GW-1:0] start);
    logic [GW-1:0] sel;
    int idx;
    sel = start;
    for (int k = int'(N_GATES) - 1; k >= 0; k--) begin
      idx = int'(start) + k;
      if (idx >= int'(N_GATES)) idx = idx - int'(N_GATES);
      if (mask[idx]) sel = GW'(idx);
    end
    return sel;
  endfunction

  always_comb begin
`ifdef EXIT_PRIORITY_EN
    cand = ((gate_req & gate_is_exit) != '0) ? (gate_req & gate_is_exit) : gate_req;
`else
    cand = gate_req;
`endif
    pick     = rr_pick(cand, rr_q);
    pick_rej = gate_is_exit[pick] ? (occupancy == 4'd0) : full;
  end

  // Next-state and next-output logic for every register.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    win_d      = win_q;
    tmo_d      = tmo_q;
    occ_d      = occupancy;
    dp_valid_d = dp_valid;
    dp_exit_d  = dp_exit;
    dp_slot_d  = dp_slot;
    dp_code_d  = dp_code;
    grant_d    = '0;
    ok_d       = 1'b0;
    for (int g = 0; g < int'(N_GATES); g++) begin
      timer_d[g] = (timer_q[g] != '0) ? timer_q[g] - TW'(1) : timer_q[g];
    end

    case (state_q)
      IDLE: begin
        if (gate_req != '0) begin
          win_d = pick;
          if (pick_rej) begin
            grant_d = N_GATES'(1) << pick;
            state_d = RESP;
          end else begin
            dp_valid_d = 1'b1;
            dp_exit_d  = gate_is_exit[pick];
            dp_slot_d  = gate_slot[3*int'(pick) +: 3];
            dp_code_d  = gate_code[8*int'(pick) +: 8];
            tmo_d      = '0;
            state_d    = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (dp_done) begin
          dp_valid_d = 1'b0;
          ok_d       = dp_ok;
          grant_d    = N_GATES'(1) << win_q;
          state_d    = RESP;
        end else if (tmo_q == CW'(DP_TIMEOUT - 1)) begin
          dp_valid_d = 1'b0;
          grant_d    = N_GATES'(1) << win_q;
          state_d    = RESP;
        end else begin
          tmo_d = tmo_q + CW'(1);
        end
      end
      RESP: begin
        // gate_ok is only set after a datapath run, so dp_exit holds the winner's type.
        if (gate_ok) begin
          occ_d          = dp_exit ? occupancy - 4'd1 : occupancy + 4'd1;
          timer_d[win_q] = TW'(OPEN_CYCLES);
        end
        rr_d    = (win_q == GW'(N_GATES - 1)) ? '0 : win_q + GW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    full_d = (occ_d == 4'(SLOTS));
    for (int g = 0; g < int'(N_GATES); g++) begin
      open_d[g] = (timer_d[g] != '0);
    end
  end

  always_ff @(posedge clock) begin
    if (g1_reset) begin
      state_q    <= IDLE;
      rr_q       <= '0;
      win_q      <= '0;
      tmo_q      <= '0;
      occupancy  <= '0;
      full       <= 1'b0;
      dp_valid   <= 1'b0;
      dp_exit    <= 1'b0;
      dp_slot    <= '0;
      dp_code    <= '0;
      gate_grant <= '0;
      gate_ok    <= 1'b0;
      gate_open  <= '0;
      for (int g = 0; g < int'(N_GATES); g++) timer_q[g] <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      win_q      <= win_d;
      tmo_q      <= tmo_d;
      occupancy  <= occ_d;
      full       <= full_d;
      dp_valid   <= dp_valid_d;
      dp_exit    <= dp_exit_d;
      dp_slot    <= dp_slot_d;
      dp_code    <= dp_code_d;
      gate_grant <= grant_d;
      gate_ok    <= ok_d;
      gate_open  <= open_d;
      for (int g = 0; g < int'(N_GATES); g++) timer_q[g] <= timer_d[g];
    end
  end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Testbench for parking_gate_arbiter: transaction table, directed corner cases and
// randomized traffic against a transaction-level model of occupancy, arbitration and timers.
module tb_parking_gate_arbiter;

  localparam int N     = 4;
  localparam int SLOTS = 8;
  localparam int OPEN  = 16;
  localparam int TMO   = 32;

  logic           clock = 1'b0;
  logic           g1_reset;
  logic [N-1:0]   gate_req, gate_is_exit;
  logic [3*N-1:0] gate_slot;
  logic [8*N-1:0] gate_code;
  logic [N-1:0]   gate_grant, gate_open;
  logic           gate_ok, dp_valid, dp_exit, dp_done, dp_ok, full;
  logic [2:0]     dp_slot;
  logic [7:0]     dp_code;
  logic [3:0]     occupancy;

  always #5 clock = ~clock;

  parking_gate_arbiter #(.N_GATES(N), .SLOTS(SLOTS), .OPEN_CYCLES(OPEN), .DP_TIMEOUT(TMO)) dut (
    .clock(clock), .g1_reset(g1_reset),
    .gate_req(gate_req), .gate_is_exit(gate_is_exit), .gate_slot(gate_slot), .gate_code(gate_code),
    .gate_grant(gate_grant), .gate_ok(gate_ok), .gate_open(gate_open),
    .dp_valid(dp_valid), .dp_exit(dp_exit), .dp_slot(dp_slot), .dp_code(dp_code),
    .dp_done(dp_done), .dp_ok(dp_ok), .occupancy(occupancy), .full(full)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int m_occ, m_rr;
  int open_until [N];

  typedef struct {
    int gate; bit ex; int slot; int code; int lat; bit dpok;
    int exp_gate; bit exp_ok; int exp_occ;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock; barrier outputs are checked every cycle against the model's open windows.
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    for (int g = 0; g < N; g++) chk("gate_open", 32'(gate_open[g]), 32'(cyc < open_until[g]));
  endtask

  function automatic int model_pick();
`ifdef EXIT_PRIORITY_EN
    for (int k = 0; k < N; k++)
      if (gate_req[(m_rr + k) % N] && gate_is_exit[(m_rr + k) % N]) return (m_rr + k) % N;
`endif
    for (int k = 0; k < N; k++)
      if (gate_req[(m_rr + k) % N]) return (m_rr + k) % N;
    return -1;
  endfunction

  task automatic add_req(input int g, input bit ex, input int slot, input int code);
    gate_req[g]         = 1'b1;
    gate_is_exit[g]     = ex;
    gate_slot[3*g +: 3] = 3'(slot);
    gate_code[8*g +: 8] = 8'(code);
  endtask

  task automatic rand_add(input int except);
    for (int g = 0; g < N; g++)
      if (!gate_req[g] && g != except && $urandom_range(3) == 0)
        add_req(g, 1'($urandom_range(1)), int'($urandom_range(7)), int'($urandom_range(255)));
  endtask

  task automatic do_reset();
    g1_reset = 1'b1;
    m_occ = 0;
    m_rr  = 0;
    for (int g = 0; g < N; g++) open_until[g] = 0;
    tick();
    g1_reset = 1'b0;
  endtask

  // Serves the next arbitration round from IDLE through the cycle after the grant.
  task automatic serve(input int lat, input bit dpok, input bit noise, output int gw, output bit gok);
    int w;
    bit ex, rej, tmo_hit;
    logic [2:0] es;
    logic [7:0] ec;
    logic [N-1:0] one;
    one = 1;
    gw  = -1;
    gok = 1'b0;
    w = model_pick();
    if (w < 0) begin
      chk("no_request_pending", 0, 1);
      return;
    end
    ex  = gate_is_exit[w];
    es  = gate_slot[3*w +: 3];
    ec  = gate_code[8*w +: 8];
    rej = ex ? (m_occ == 0) : (m_occ == SLOTS);
    tick();
    if (!rej) begin
      chk("dp_valid_rise", 32'(dp_valid), 1);
      chk("dp_exit", 32'(dp_exit), 32'(ex));
      chk("dp_slot", 32'(dp_slot), 32'(es));
      chk("dp_code", 32'(dp_code), 32'(ec));
      chk("grant_early", 32'(gate_grant), 0);
      tmo_hit = 1'b1;
      for (int n = 0; n < TMO; n++) begin
        dp_done = (n == lat);
        dp_ok   = (n == lat) ? dpok : 1'($urandom_range(1));
        if (noise) begin
          rand_add(w);
          if ($urandom_range(7) == 0) gate_req[w] = 1'b0;
        end
        tick();
        if (n == lat) begin
          tmo_hit = 1'b0;
          break;
        end
        if (n < TMO - 1) begin
          chk("dp_valid_hold", 32'(dp_valid), 1);
          chk("grant_wait", 32'(gate_grant), 0);
        end
      end
      dp_done = 1'b0;
      gok = tmo_hit ? 1'b0 : dpok;
    end else begin
      chk("reject_no_dp", 32'(dp_valid), 0);
    end
    chk("grant", 32'(gate_grant), 32'(one << w));
    chk("gate_ok", 32'(gate_ok), 32'(gok));
    chk("dp_valid_fall", 32'(dp_valid), 0);
    for (int g = 0; g < N; g++) if (gate_grant == (one << g)) gw = g;
    gate_req[w] = 1'b0;
    if (gok) begin
      m_occ += ex ? -1 : 1;
      open_until[w] = cyc + 1 + OPEN;
    end
    m_rr = (w + 1) % N;
    if (noise) dp_done = 1'($urandom_range(1));
    tick();
    dp_done = 1'b0;
    chk("grant_single", 32'(gate_grant), 0);
    chk("occupancy", 32'(occupancy), 32'(m_occ));
    chk("full", 32'(full), 32'(m_occ == SLOTS));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int gw, lat;
    bit gok, dpok;
    g1_reset = 1'b1; gate_req = '0; gate_is_exit = '0; gate_slot = '0; gate_code = '0;
    dp_done = 1'b0; dp_ok = 1'b0;
    for (int g = 0; g < N; g++) open_until[g] = 0;

    tbl.push_back('{0, 1'b1, 3, 8'h11, 0, 1'b1, 0, 1'b0, 0});
    tbl.push_back('{1, 1'b0, 0, 8'h00, 3, 1'b1, 1, 1'b1, 1});
    tbl.push_back('{2, 1'b0, 0, 8'h00, 0, 1'b1, 2, 1'b1, 2});
    tbl.push_back('{3, 1'b0, 0, 8'h00, 1, 1'b0, 3, 1'b0, 2});
    tbl.push_back('{0, 1'b1, 5, 8'hA5, 2, 1'b1, 0, 1'b1, 1});
    tbl.push_back('{1, 1'b0, 0, 8'h00, 40, 1'b1, 1, 1'b0, 1});
    tbl.push_back('{2, 1'b0, 0, 8'h00, 31, 1'b1, 2, 1'b1, 2});
    tbl.push_back('{3, 1'b0, 0, 8'h00, 0, 1'b1, 3, 1'b1, 3});
    tbl.push_back('{0, 1'b0, 0, 8'h00, 1, 1'b1, 0, 1'b1, 4});
    tbl.push_back('{1, 1'b0, 0, 8'h00, 2, 1'b1, 1, 1'b1, 5});
    tbl.push_back('{2, 1'b0, 0, 8'h00, 0, 1'b1, 2, 1'b1, 6});
    tbl.push_back('{3, 1'b0, 0, 8'h00, 1, 1'b1, 3, 1'b1, 7});
    tbl.push_back('{0, 1'b0, 0, 8'h00, 0, 1'b1, 0, 1'b1, 8});
    tbl.push_back('{1, 1'b0, 0, 8'h00, 0, 1'b1, 1, 1'b0, 8});
    tbl.push_back('{2, 1'b1, 7, 8'hFF, 1, 1'b1, 2, 1'b1, 7});
    tbl.push_back('{3, 1'b0, 0, 8'h00, 0, 1'b1, 3, 1'b1, 8});

    tick();
    do_reset();
    chk("rst_grant", 32'(gate_grant), 0);
    chk("rst_ok", 32'(gate_ok), 0);
    chk("rst_dp_valid", 32'(dp_valid), 0);
    chk("rst_dp_fields", {22'd0, dp_exit, dp_slot, dp_code}, 0);
    chk("rst_occupancy", 32'(occupancy), 0);
    chk("rst_full", 32'(full), 0);

    foreach (tbl[i]) begin
      add_req(tbl[i].gate, tbl[i].ex, tbl[i].slot, tbl[i].code);
      serve(tbl[i].lat, tbl[i].dpok, 1'b0, gw, gok);
      chk("tbl_gate", 32'(gw), 32'(tbl[i].exp_gate));
      chk("tbl_ok", 32'(gok), 32'(tbl[i].exp_ok));
      chk("tbl_occ", 32'(occupancy), 32'(tbl[i].exp_occ));
    end

    // Reset in the middle of a datapath transaction.
    add_req(1, 1'b1, 2, 8'h33);
    tick();
    chk("mid_dp_valid", 32'(dp_valid), 1);
    tick();
    g1_reset = 1'b1;
    gate_req = '0;
    m_occ = 0; m_rr = 0;
    for (int g = 0; g < N; g++) open_until[g] = 0;
    tick();
    g1_reset = 1'b0;
    chk("mid_rst_dp_valid", 32'(dp_valid), 0);
    chk("mid_rst_occ", 32'(occupancy), 0);
    chk("mid_rst_full", 32'(full), 0);
    chk("mid_rst_grant", 32'(gate_grant), 0);
    for (int i = 0; i < 3; i++) begin
      dp_done = 1'b1;
      tick();
      chk("post_rst_no_grant", 32'(gate_grant), 0);
      chk("post_rst_no_dp", 32'(dp_valid), 0);
    end
    dp_done = 1'b0;

    // Round-robin order and the exit-priority case.
    add_req(0, 1'b0, 0, 0);
    add_req(2, 1'b0, 0, 0);
    serve(1, 1'b1, 1'b0, gw, gok);
    chk("rr_first_gate0", 32'(gw), 0);
    serve(1, 1'b1, 1'b0, gw, gok);
    chk("rr_second_gate2", 32'(gw), 2);
    add_req(0, 1'b0, 0, 0);
    add_req(3, 1'b0, 0, 0);
    serve(1, 1'b1, 1'b0, gw, gok);
    chk("rr_ptr3_gate3", 32'(gw), 3);
    add_req(3, 1'b1, 4, 8'h5A);
    serve(1, 1'b1, 1'b0, gw, gok);
`ifdef EXIT_PRIORITY_EN
    chk("prio_first", 32'(gw), 3);
`else
    chk("prio_first", 32'(gw), 0);
`endif
    serve(1, 1'b1, 1'b0, gw, gok);
    chk("prio_occ", 32'(occupancy), 3);

    for (int t = 0; t < 150; t++) begin
      for (int k = 0; k < 20 && gate_req == '0; k++) rand_add(-1);
      if (gate_req == '0) add_req(int'($urandom_range(N - 1)), 1'($urandom_range(1)), 1, 1);
      lat = int'($urandom_range(19));
      lat = (lat < 15) ? lat % 5 : (lat < 17) ? TMO - 1 : TMO + 8;
      dpok = ($urandom_range(3) != 0);
      serve(lat, dpok, 1'b1, gw, gok);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
